apb_mem_slave: RTL
==================

Name: apb_mem_slave

Overview:
- Parametrised APB memory-mapped slave; successor to the fixed 8-bit, 256-entry APB slave memories in the APB subsystem.
- Adds configurable data/address width and depth, byte-lane strobes, programmable wait states, and error response (PSLVERR) for out-of-range or misaligned accesses.
- Sits behind the APB master/decoder as one PSEL target.

Parameters:
- DATA_WIDTH, 32: PWDATA/PRDATA width; must be 8, 16 or 32.
- ADDR_WIDTH, 12: PADDR width (byte address).
- MEM_DEPTH, 256: number of DATA_WIDTH-bit words; must be a power of two and ≤ 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0: extra access-phase cycles before PREADY (0..15).
- CLEAR_ON_RESET, 1: 1 = all words zeroed on reset; 0 = contents undefined after reset.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset; one clock; reset is synchronous and active-high
- PSEL_i  in  1  slave select
- PENABLE_i  in  1  access phase
- PWRITE_i  in  1  1 = write, 0 = read
- PADDR_i  in  ADDR_WIDTH  byte address
- PWDATA_i  in  DATA_WIDTH  write data
- PSTRB_i  in  DATA_WIDTH/8  byte-lane write strobes; ignored on reads
- PRDATA_o  out  DATA_WIDTH  read data
- PREADY_o  out  1  transfer completes this cycle
- PSLVERR_o  out  1  error response; valid only while PREADY_o is high

Behaviour:
- Reset, sampled on the PCLK edge while PRESET = 1:
  - state goes to IDLE; wait counter = 0; read-data register = 0.
  - PREADY_o, PSLVERR_o and PRDATA_o are all 0.
  - With CLEAR_ON_RESET = 1, every word is 0.
  - Reset mid-transfer aborts the transfer; a pending write is discarded.
- Decode:
  - LSB = log2(DATA_WIDTH/8); word index = PADDR_i[ADDR_WIDTH-1:LSB].
  - err = (PADDR_i[LSB-1:0] != 0) or (index ≥ MEM_DEPTH). For DATA_WIDTH = 8 there is no alignment check.
- FSM states:
  - IDLE: no transfer in progress.
  - ACCESS: transfer in progress.
- Transitions:
  - IDLE with PSEL_i & !PENABLE_i (setup): latch err; load counter = WAIT_STATES; capture mem[index] into the read register (0 if err); go to ACCESS.
  - ACCESS with PSEL_i & PENABLE_i and counter != 0: PREADY_o = 0; decrement counter.
  - ACCESS with PSEL_i & PENABLE_i and counter == 0: PREADY_o = 1 (combinational from state/counter); PSLVERR_o = latched err. At this edge:
    - if PWRITE_i and !err, write lanes where PSTRB_i[b] = 1; other lanes keep their value.
    - go to IDLE.
  - ACCESS with !PSEL_i (master abort): go to IDLE; no write; no PREADY.
  - IDLE with PSEL_i & PENABLE_i (access without setup): PREADY_o = 1, PSLVERR_o = 1, no write, stay in IDLE.
- Latency: PREADY_o rises in access cycle WAIT_STATES+1. With WAIT_STATES = 0, each transfer is 2 cycles (setup + access).
- Back-to-back transfers: a new setup in the cycle after completion is accepted with no idle cycle.
- PRDATA_o = read register when PREADY_o & !PWRITE_i, else 0. Read data is the memory value at setup, so a write to the same word in the previous transfer is visible.
- Address, PWRITE and PWDATA are used as presented in the completing cycle; the master holds them stable per APB.
- Outside a completing cycle, PSLVERR_o = 0.
- PSTRB_i = 0 on a write is legal: a no-op with PREADY and no error.

Decomposition:
- Package apb_pkg:
  - apb_state_e {IDLE, ACCESS}.
  - localparams STRB_WIDTH = DATA_WIDTH/8 and LSB.
  - helper function for word index and error.
- Sub-module apb_mem_array: synchronous byte-lane-write memory (clk, rst, clear enable, we, strb, index, wdata, rdata) with parameters DATA_WIDTH and MEM_DEPTH.

Test Plan:
1. Basic access (defaults, WAIT_STATES = 0): write 0xDEADBEEF to 0x010 with PSTRB = 0xF, then read 0x010 → PREADY in the first access cycle both times; PRDATA = 0xDEADBEEF; PSLVERR = 0.
2. Byte strobes: word 0x020 = 0x11223344; write 0xAABBCCDD with PSTRB = 0x5; read 0x020 → 0x11BB33DD.
3. Wait states (WAIT_STATES = 3): write 0x000 then read → PREADY low for 3 access cycles and high on the 4th; memory is unchanged until the PREADY edge.
4. Errors:
   - Read 0x400 (index 256) → PSLVERR = 1, PRDATA = 0.
   - Write 0x002 (misaligned) → PSLVERR = 1, memory unchanged.
   - PSEL & PENABLE with no setup → PREADY = 1, PSLVERR = 1.
5. Reset mid-write (WAIT_STATES = 2): assert PRESET during a wait cycle → PREADY and PSLVERR are 0 next cycle; target word reads 0.
6. Back-to-back and abort:
   - Write, read, write to 0x004, 0x004, 0x008 with no idle cycles → each completes in 2 cycles; the read returns the first write's data.
   - Deassert PSEL mid-wait → no write; state returns to IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and decode helpers for the parametrised APB memory slave.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Byte lanes per data word.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Number of byte-offset bits below the word index.
  function automatic int unsigned lsb_of(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Word index of a byte address.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned lsb);
    return addr >> lsb;
  endfunction

  // Misaligned or past the end of the array; with lsb = 0 the mask is empty,
  // so byte-wide memories never report misalignment.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input int unsigned lsb,
                                    input int unsigned depth);
    logic [31:0] mask;
    mask = (32'd1 << lsb) - 32'd1;
    return ((addr & mask) != '0) || (word_index(addr, lsb) >= depth);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word-addressed storage with per-byte write enables and asynchronous read.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr_en,
  input  logic                              we,
  input  logic [strb_width(DATA_WIDTH)-1:0] strb,
  input  logic [IDX_W-1:0]                  index,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Optional bulk clear on reset, otherwise byte-lane writes.
  always_ff @(posedge clk) begin
    if (rst && clr_en) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (strb[b]) begin
          mem[index][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read port sampled by the slave during the setup phase.
  always_comb begin
    rdata = mem[index];
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave: setup/access FSM, wait-state counter, error response.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned WAIT_STATES    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL_i,
  input  logic                    PENABLE_i,
  input  logic                    PWRITE_i,
  input  logic [ADDR_WIDTH-1:0]   PADDR_i,
  input  logic [DATA_WIDTH-1:0]   PWDATA_i,
  input  logic [DATA_WIDTH/8-1:0] PSTRB_i,
  output logic [DATA_WIDTH-1:0]   PRDATA_o,
  output logic                    PREADY_o,
  output logic                    PSLVERR_o
);

  localparam int unsigned LSB       = lsb_of(DATA_WIDTH);
  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  apb_state_e            state;
  logic [3:0]            cnt;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rd_q;

  logic [31:0]           addr_ext;
  logic                  dec_err;
  logic [IDX_W-1:0]      mem_index;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  setup;
  logic                  access;
  logic                  complete;
  logic                  no_setup;
  logic                  mem_we;

  // Address decode and transfer-phase qualifiers.
  always_comb begin
    addr_ext  = 32'(PADDR_i);
    dec_err   = addr_err(addr_ext, LSB, MEM_DEPTH);
    mem_index = IDX_W'(addr_ext >> LSB);
    setup     = PSEL_i && !PENABLE_i;
    access    = PSEL_i && PENABLE_i;
    complete  = (state == ACCESS) && access && (cnt == '0);
    no_setup  = (state == IDLE) && access;
    // Reset wins over a completing write even when the array is not cleared.
    mem_we    = complete && PWRITE_i && !err_q && !PRESET;
  end

  // Response outputs, all derived from current state and bus inputs.
  always_comb begin
    PREADY_o  = complete || no_setup;
    PSLVERR_o = (complete && err_q) || no_setup;
    PRDATA_o  = (PREADY_o && !PWRITE_i) ? rd_q : '0;
  end

  // Transfer FSM, wait counter and setup-time read capture.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            cnt   <= WAIT_INIT;
            err_q <= dec_err;
            rd_q  <= dec_err ? '0 : mem_rdata;
          end
        end
        ACCESS: begin
          if (!PSEL_i) begin
            state <= IDLE;
          end else if (PENABLE_i) begin
            if (cnt != '0) begin
              cnt <= cnt - 4'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr_en (CLEAR_ON_RESET),
    .we     (mem_we),
    .strb   (PSTRB_i),
    .index  (mem_index),
    .wdata  (PWDATA_i),
    .rdata  (mem_rdata)
  );

endmodule
